// File: rtl/dft_frame_feeder.sv
// Ping-pong frame packer feeding the streaming DFT: gathers 16*FRAME_WORDS samples per bank,
// then launches the frame with a one-cycle next pulse and presents one 16-lane word per cycle.
module dft_frame_feeder #(
    parameter int unsigned FRAME_WORDS = 2,
    parameter int unsigned W           = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         tx_enable,
    output logic         next,
    output logic [W-1:0] X0,
    output logic [W-1:0] X1,
    output logic [W-1:0] X2,
    output logic [W-1:0] X3,
    output logic [W-1:0] X4,
    output logic [W-1:0] X5,
    output logic [W-1:0] X6,
    output logic [W-1:0] X7,
    output logic [W-1:0] X8,
    output logic [W-1:0] X9,
    output logic [W-1:0] X10,
    output logic [W-1:0] X11,
    output logic [W-1:0] X12,
    output logic [W-1:0] X13,
    output logic [W-1:0] X14,
    output logic [W-1:0] X15,
    output logic         busy,
    output logic [15:0]  frame_count
);

    localparam int unsigned LANES = 16;
    localparam int unsigned DEPTH = LANES * FRAME_WORDS;
    localparam int unsigned WI_W  = $clog2(DEPTH);
    localparam int unsigned WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WI_W-1:0] WI_MAX  = WI_W'(DEPTH - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_WORDS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;

    logic [1:0]      state_q, state_nxt;
    logic            wb_q, wb_nxt;
    logic            rb_q, rb_nxt;
    logic [WI_W-1:0] wi_q, wi_nxt;
    logic [WC_W-1:0] wc_q, wc_nxt;
    logic [1:0]      full_q, full_nxt, full_set, full_clr;
    logic            s_ready_q, next_q, busy_q;
    logic [15:0]     frame_cnt_q;
    logic [W-1:0]    x_q [LANES];
    logic [W-1:0]    x_nxt [LANES];
    logic            xfer, cnt_inc, load_en;
    logic [WC_W-1:0] load_word;
    logic [WC_W-1:0] w_word;

    logic [W-1:0] mem [2][FRAME_WORDS][LANES];

    assign xfer   = s_valid && s_ready_q;
    assign w_word = WC_W'(wi_q >> 4);

    // Sample storage; contents need no reset since full flags gate every read.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wb_q][w_word][wi_q[3:0]] <= s_data;
        end
    end

    // Fill-side pointer advance
    always_comb begin
        wb_nxt   = wb_q;
        wi_nxt   = wi_q;
        full_set = '0;
        if (xfer) begin
            if (wi_q == WI_MAX) begin
                full_set[wb_q] = 1'b1;
                wb_nxt         = ~wb_q;
                wi_nxt         = '0;
            end else begin
                wi_nxt = wi_q + WI_W'(1);
            end
        end
    end

    // Emit FSM next-state and word-load selection
    always_comb begin
        state_nxt = state_q;
        wc_nxt    = wc_q;
        rb_nxt    = rb_q;
        full_clr  = '0;
        cnt_inc   = 1'b0;
        load_en   = 1'b0;
        load_word = wc_q;
        case (state_q)
            IDLE: begin
                if (full_q[rb_q] && tx_enable) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = SEND;
                wc_nxt    = '0;
                load_en   = 1'b1;
                load_word = '0;
            end
            SEND: begin
                if (wc_q == WC_LAST) begin
                    full_clr[rb_q] = 1'b1;
                    rb_nxt         = ~rb_q;
                    cnt_inc        = 1'b1;
                    state_nxt      = (full_q[~rb_q] && tx_enable) ? LAUNCH : IDLE;
                end else begin
                    wc_nxt    = wc_q + WC_W'(1);
                    load_en   = 1'b1;
                    load_word = wc_q + WC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign full_nxt = (full_q | full_set) & ~full_clr;

    always_comb begin
        for (int k = 0; k < int'(LANES); k++) begin
            x_nxt[k] = load_en ? mem[rb_q][load_word][k] : '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wi_q        <= '0;
            wc_q        <= '0;
            full_q      <= '0;
            s_ready_q   <= 1'b1;
            next_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < int'(LANES); k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q   <= state_nxt;
            wb_q      <= wb_nxt;
            rb_q      <= rb_nxt;
            wi_q      <= wi_nxt;
            wc_q      <= wc_nxt;
            full_q    <= full_nxt;
            s_ready_q <= !full_nxt[wb_nxt];
            next_q    <= (state_nxt == LAUNCH);
            busy_q    <= (|full_nxt) || (state_nxt != IDLE);
            if (cnt_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            for (int k = 0; k < int'(LANES); k++) begin
                x_q[k] <= x_nxt[k];
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign next        = next_q;
    assign busy        = busy_q;
    assign frame_count = frame_cnt_q;
    assign X0  = x_q[0];
    assign X1  = x_q[1];
    assign X2  = x_q[2];
    assign X3  = x_q[3];
    assign X4  = x_q[4];
    assign X5  = x_q[5];
    assign X6  = x_q[6];
    assign X7  = x_q[7];
    assign X8  = x_q[8];
    assign X9  = x_q[9];
    assign X10 = x_q[10];
    assign X11 = x_q[11];
    assign X12 = x_q[12];
    assign X13 = x_q[13];
    assign X14 = x_q[14];
    assign X15 = x_q[15];

endmodule
